// File: rtl/key_event_ctrl.sv
// Debounced multi-key controller: press/release/long/repeat events arbitrated round-robin onto
// one valid/ready port. Define KEY_AUTO_REPEAT_EN to enable REPEAT events after LONG.
module key_event_ctrl #(
    parameter int unsigned N_KEYS       = 4,
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned STABLE_TICKS = 8,
    parameter int unsigned LONG_TICKS   = 64,
    parameter int unsigned REPEAT_TICKS = 16
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [N_KEYS-1:0]                              key_raw_i,
    input  logic                                           evt_ready_i,
    input  logic                                           ovf_clr_i,
    output logic                                           evt_valid_o,
    output logic [((N_KEYS > 1) ? $clog2(N_KEYS) : 1)-1:0] evt_key_o,
    output logic [1:0]                                     evt_type_o,
    output logic [N_KEYS-1:0]                              key_pressed_o,
    output logic                                           ovf_o
);
    localparam int unsigned KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam logic [1:0] EvPress = 2'd0, EvRelease = 2'd1, EvLong = 2'd2, EvRepeat = 2'd3;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit RepeatEn = 1'b1;
`else
    localparam bit RepeatEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StHeld, StRepeat} key_st_e;

    logic [N_KEYS-1:0] sync1_q, sync2_q, key_lvl;
    logic [N_KEYS-1:0] pressed_q, pressed_d, slot_vld_q, slot_vld_d, raise;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [7:0]        stab_q [N_KEYS];
    logic [7:0]        stab_d [N_KEYS];
    logic [15:0]       hold_q [N_KEYS];
    logic [15:0]       hold_d [N_KEYS];
    key_st_e           state_q [N_KEYS];
    key_st_e           state_d [N_KEYS];
    logic [1:0]        slot_type_q [N_KEYS];
    logic [1:0]        slot_type_d [N_KEYS];
    logic [1:0]        raise_type [N_KEYS];
    logic [8:0]        stab_inc;
    logic [16:0]       hold_inc;
    logic [15:0]       hold_sat;
    logic              evt_valid_q, evt_valid_d, ovf_q, ovf_d, ovf_set, grant, out_free;
    logic [KW-1:0]     evt_key_q, evt_key_d, rr_ptr_q, rr_ptr_d, grant_idx, idx;
    logic [1:0]        evt_type_q, evt_type_d;

    assign key_lvl    = ~sync2_q;
    assign tick       = (32'(tick_cnt_q) == TICK_DIV - 1);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    always_comb begin
        pressed_d = pressed_q;
        raise     = '0;
        stab_inc  = '0;
        hold_inc  = '0;
        hold_sat  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            stab_d[i]     = stab_q[i];
            hold_d[i]     = hold_q[i];
            state_d[i]    = state_q[i];
            raise_type[i] = EvPress;
            if (tick) begin
                stab_inc = {1'b0, stab_q[i]} + 9'd1;
                hold_inc = {1'b0, hold_q[i]} + 17'd1;
                hold_sat = hold_inc[16] ? 16'hFFFF : hold_inc[15:0];
                if (key_lvl[i] != pressed_q[i]) begin
                    if (32'(stab_inc) == STABLE_TICKS) begin
                        pressed_d[i]  = ~pressed_q[i];
                        stab_d[i]     = '0;
                        raise[i]      = 1'b1;
                        raise_type[i] = pressed_q[i] ? EvRelease : EvPress;
                    end else begin
                        stab_d[i] = stab_inc[7:0];
                    end
                end else begin
                    stab_d[i] = '0;
                end
                // A release on this tick overrides any LONG/REPEAT due on the same tick.
                if (raise[i] && pressed_q[i]) begin
                    state_d[i] = StIdle;
                    hold_d[i]  = '0;
                end else begin
                    case (state_q[i])
                        StIdle: begin
                            if (raise[i]) begin
                                state_d[i] = StHeld;
                                hold_d[i]  = '0;
                            end
                        end
                        StHeld: begin
                            if (32'(hold_sat) == LONG_TICKS) begin
                                raise[i]      = 1'b1;
                                raise_type[i] = EvLong;
                                state_d[i]    = StRepeat;
                                hold_d[i]     = '0;
                            end else begin
                                hold_d[i] = hold_sat;
                            end
                        end
                        StRepeat: begin
                            if (RepeatEn) begin
                                if (32'(hold_sat) == REPEAT_TICKS) begin
                                    raise[i]      = 1'b1;
                                    raise_type[i] = EvRepeat;
                                    hold_d[i]     = '0;
                                end else begin
                                    hold_d[i] = hold_sat;
                                end
                            end
                        end
                        default: state_d[i] = StIdle;
                    endcase
                end
            end
        end
    end

    always_comb begin
        out_free  = !evt_valid_q || evt_ready_i;
        grant     = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int unsigned off = 0; off < N_KEYS; off++) begin
            idx = KW'((32'(rr_ptr_q) + off) % N_KEYS);
            if (out_free && !grant && slot_vld_q[idx]) begin
                grant     = 1'b1;
                grant_idx = idx;
            end
        end

        rr_ptr_d    = rr_ptr_q;
        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        evt_type_d  = evt_type_q;
        if (grant) begin
            rr_ptr_d    = (32'(grant_idx) == N_KEYS - 1) ? '0 : grant_idx + KW'(1);
            evt_valid_d = 1'b1;
            evt_key_d   = grant_idx;
            evt_type_d  = slot_type_q[grant_idx];
        end else if (evt_ready_i) begin
            evt_valid_d = 1'b0;
        end

        slot_vld_d  = slot_vld_q;
        slot_type_d = slot_type_q;
        ovf_set     = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (grant && grant_idx == KW'(i)) slot_vld_d[i] = 1'b0;
            if (raise[i]) begin
                if (!slot_vld_q[i] || (grant && grant_idx == KW'(i))) begin
                    slot_vld_d[i]  = 1'b1;
                    slot_type_d[i] = raise_type[i];
                end else begin
                    ovf_set = 1'b1;
                end
            end
        end
        ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            tick_cnt_q  <= '0;
            pressed_q   <= '0;
            slot_vld_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            evt_type_q  <= '0;
            rr_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < N_KEYS; i++) begin
                stab_q[i]      <= '0;
                hold_q[i]      <= '0;
                state_q[i]     <= StIdle;
                slot_type_q[i] <= '0;
            end
        end else begin
            sync1_q     <= key_raw_i;
            sync2_q     <= sync1_q;
            tick_cnt_q  <= tick_cnt_d;
            pressed_q   <= pressed_d;
            slot_vld_q  <= slot_vld_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_type_q  <= evt_type_d;
            rr_ptr_q    <= rr_ptr_d;
            ovf_q       <= ovf_d;
            for (int i = 0; i < N_KEYS; i++) begin
                stab_q[i]      <= stab_d[i];
                hold_q[i]      <= hold_d[i];
                state_q[i]     <= state_d[i];
                slot_type_q[i] <= slot_type_d[i];
            end
        end
    end

    assign evt_valid_o   = evt_valid_q;
    assign evt_key_o     = evt_key_q;
    assign evt_type_o    = evt_type_q;
    assign key_pressed_o = pressed_q;
    assign ovf_o         = ovf_q;
endmodule
